// File: rtl/alien_pkg.sv
// alien_pkg: shared colour constants, FSM state encoding and colour helper for the alien formation.
// Contents: COLOR_NONE, ALIEN_COLOR0..3, fsmState (WAIT/SCAN/STEP), colorOf().
package alien_pkg;
  localparam logic [2:0] COLOR_NONE   = 3'd0;
  localparam logic [2:0] ALIEN_COLOR0 = 3'd2;
  localparam logic [2:0] ALIEN_COLOR1 = 3'd3;
  localparam logic [2:0] ALIEN_COLOR2 = 3'd4;
  localparam logic [2:0] ALIEN_COLOR3 = 3'd5;
  typedef enum logic [1:0] {WAIT, SCAN, STEP} fsmState;
  function automatic logic [2:0] colorOf(input logic [1:0] k);
    return k == 2'd0 ? ALIEN_COLOR0 : k == 2'd1 ? ALIEN_COLOR1 : k == 2'd2 ? ALIEN_COLOR2 : ALIEN_COLOR3;
  endfunction
endpackage

// File: rtl/alien_formation_if.sv
// alien_formation_if: frame/pixel/projectile inputs and formation status outputs of alien_formation.
// master: drives frameTick, hPos, vPos, hitValid, hitX, hitY; reads the formation outputs.
// slave : the formation; drives xAlien, yAlien, alive, aliveCount, colorAlien, hitKill, hitIndex, allDead, invaded.
interface alien_formation_if #(parameter int ROWS = 4, parameter int COLS = 8);
  localparam int N = ROWS * COLS;
  logic frameTick;
  logic [9:0] hPos, vPos;
  logic hitValid;
  logic [9:0] hitX, hitY;
  logic [9:0] xAlien, yAlien;
  logic [N-1:0] alive;
  logic [$clog2(N+1)-1:0] aliveCount;
  logic [2:0] colorAlien;
  logic hitKill;
  logic [$clog2(N)-1:0] hitIndex;
  logic allDead;
  logic invaded;
  modport master (
    output frameTick, hPos, vPos, hitValid, hitX, hitY,
    input  xAlien, yAlien, alive, aliveCount, colorAlien, hitKill, hitIndex, allDead, invaded
  );
  modport slave (
    input  frameTick, hPos, vPos, hitValid, hitX, hitY,
    output xAlien, yAlien, alive, aliveCount, colorAlien, hitKill, hitIndex, allDead, invaded
  );
endinterface

// File: rtl/alien_locate.sv
// alien_locate: combinational point-to-cell locator for the alien grid.
// Inputs px/py (point), xAlien/yAlien (origin), alive (mask); outputs hit (point inside a live cell) and index (r*COLS+c).
module alien_locate import alien_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 8,
  parameter int ALIEN_W = 20,
  parameter int ALIEN_H = 10,
  parameter int PITCH_X = 40,
  parameter int PITCH_Y = 20
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] xAlien,
  input  logic [9:0] yAlien,
  input  logic [ROWS*COLS-1:0] alive,
  output logic hit,
  output logic [$clog2(ROWS*COLS)-1:0] index
);
  localparam int IW = $clog2(ROWS * COLS);
  // 11-bit arithmetic keeps cells past x/y = 1023 from wrapping back onto the screen.
  always_comb begin
    hit = 1'b0;
    index = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[r*COLS+c] &&
            {1'b0, px} >= 11'(xAlien) + 11'(PITCH_X * c) &&
            {1'b0, px} <  11'(xAlien) + 11'(PITCH_X * c + ALIEN_W) &&
            {1'b0, py} >= 11'(yAlien) + 11'(PITCH_Y * r) &&
            {1'b0, py} <  11'(yAlien) + 11'(PITCH_Y * r + ALIEN_H)) begin
          hit = 1'b1;
          index = IW'(r * COLS + c);
        end
  end
endmodule

// File: rtl/alien_formation.sv
// alien_formation: owns origin, march direction and alive mask; marches, kills on hits, colours pixels.
// Ports: clk, rst_n (synchronous, active low), bus (alien_formation_if.slave).
// Build option: ALIEN_SPEEDUP_EN makes the march period max(1, aliveCount >> 2) instead of MOVE_PERIOD.
module alien_formation import alien_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 8,
  parameter int ALIEN_W = 20,
  parameter int ALIEN_H = 10,
  parameter int PITCH_X = 40,
  parameter int PITCH_Y = 20,
  parameter int START_X = 100,
  parameter int START_Y = 40,
  parameter int X_MIN = 8,
  parameter int X_MAX = 631,
  parameter int Y_MAX = 440,
  parameter int STEP_X = 4,
  parameter int STEP_Y = 10,
  parameter int MOVE_PERIOD = 8
) (
  input logic clk,
  input logic rst_n,
  alien_formation_if.slave bus
);
  localparam int N = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int FW = $clog2(MOVE_PERIOD + N + 1);
  fsmState state;
  logic [9:0] xAlien, yAlien, nextX, nextY;
  logic dirLeft, nextDir, seenLive, invaded, hitKill;
  logic [N-1:0] alive;
  logic [CW-1:0] aliveCount;
  logic [2:0] colorAlien;
  logic [IW-1:0] hitIndex, scanIdx, scanCol, scanRow, minCol, maxCol, maxRow;
  logic [FW-1:0] frameCnt, period;
  logic pixHit, prjHit, edgeHit;
  logic [IW-1:0] pixIdx, prjIdx;
  logic [10:0] rightEdge, leftEdge, lowEdge;
  alien_locate #(.ROWS(ROWS), .COLS(COLS), .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y))
    pixLoc (.px(bus.hPos), .py(bus.vPos), .xAlien(xAlien), .yAlien(yAlien), .alive(alive), .hit(pixHit), .index(pixIdx));
  alien_locate #(.ROWS(ROWS), .COLS(COLS), .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y))
    prjLoc (.px(bus.hitX), .py(bus.hitY), .xAlien(xAlien), .yAlien(yAlien), .alive(alive), .hit(prjHit), .index(prjIdx));
  always_comb begin
`ifdef ALIEN_SPEEDUP_EN
    period = (aliveCount >> 2) == '0 ? FW'(1) : FW'(aliveCount >> 2);
`else
    period = FW'(MOVE_PERIOD);
`endif
    scanCol = IW'(scanIdx % COLS);
    scanRow = IW'(scanIdx / COLS);
    rightEdge = 11'(xAlien) + 11'(PITCH_X) * 11'(maxCol) + 11'(ALIEN_W + STEP_X);
    leftEdge = 11'(xAlien) + 11'(PITCH_X) * 11'(minCol);
    edgeHit = dirLeft ? leftEdge < 11'(X_MIN + STEP_X) : rightEdge > 11'(X_MAX);
    nextX = !seenLive || edgeHit ? xAlien : dirLeft ? xAlien - 10'(STEP_X) : xAlien + 10'(STEP_X);
    nextY = seenLive && edgeHit ? yAlien + 10'(STEP_Y) : yAlien;
    nextDir = seenLive && edgeHit ? !dirLeft : dirLeft;
    lowEdge = 11'(nextY) + 11'(PITCH_Y) * 11'(maxRow) + 11'(ALIEN_H);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT;
      xAlien <= 10'(START_X);
      yAlien <= 10'(START_Y);
      dirLeft <= 1'b0;
      alive <= '1;
      aliveCount <= CW'(N);
      colorAlien <= COLOR_NONE;
      hitKill <= 1'b0;
      hitIndex <= '0;
      invaded <= 1'b0;
      frameCnt <= '0;
      scanIdx <= '0;
      minCol <= '0;
      maxCol <= '0;
      maxRow <= '0;
      seenLive <= 1'b0;
    end else begin
      colorAlien <= pixHit ? colorOf(pixIdx[1:0]) : COLOR_NONE;
      hitKill <= bus.hitValid && prjHit;
      if (bus.hitValid && prjHit) begin
        alive[prjIdx] <= 1'b0;
        aliveCount <= aliveCount - 1'b1;
        hitIndex <= prjIdx;
      end
      case (state)
        WAIT: if (bus.frameTick) begin
          // >= rather than == so a period that shrinks below the count still fires.
          if (frameCnt >= period - 1'b1) begin
            frameCnt <= '0;
            state <= SCAN;
            scanIdx <= '0;
            minCol <= IW'(COLS - 1);
            maxCol <= '0;
            maxRow <= '0;
            seenLive <= 1'b0;
          end else frameCnt <= frameCnt + 1'b1;
        end
        SCAN: begin
          if (alive[scanIdx]) begin
            seenLive <= 1'b1;
            if (scanCol < minCol) minCol <= scanCol;
            if (scanCol > maxCol) maxCol <= scanCol;
            if (scanRow > maxRow) maxRow <= scanRow;
          end
          scanIdx <= scanIdx + 1'b1;
          if (scanIdx == IW'(N - 1)) state <= STEP;
        end
        STEP: begin
          xAlien <= nextX;
          yAlien <= nextY;
          dirLeft <= nextDir;
          if (seenLive && lowEdge >= 11'(Y_MAX)) invaded <= 1'b1;
          state <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end
  assign bus.xAlien = xAlien;
  assign bus.yAlien = yAlien;
  assign bus.alive = alive;
  assign bus.aliveCount = aliveCount;
  assign bus.colorAlien = colorAlien;
  assign bus.hitKill = hitKill;
  assign bus.hitIndex = hitIndex;
  assign bus.allDead = aliveCount == '0;
  assign bus.invaded = invaded;
endmodule

// File: tb/tb_alien_formation.sv
// tb_alien_formation: directed self-checking bench for alien_formation (MOVE_PERIOD=1, 4x8 grid).
module tb_alien_formation;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  alien_formation_if #(.ROWS(4), .COLS(8)) bus ();
  alien_formation #(.MOVE_PERIOD(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pix(input string tag, input int x, input int y, input int exp);
    bus.hPos = 10'(x);
    bus.vPos = 10'(y);
    cyc(1);
    chk(tag, 32'(bus.colorAlien), 32'(exp));
  endtask
  task automatic shoot(input int x, input int y);
    bus.hitValid = 1'b1;
    bus.hitX = 10'(x);
    bus.hitY = 10'(y);
    cyc(1);
    bus.hitValid = 1'b0;
  endtask
  task automatic kill(input string tag, input int x, input int y, input int k);
    shoot(x, y);
    chk({tag, "_kill"}, 32'(bus.hitKill), 1);
    chk({tag, "_idx"}, 32'(bus.hitIndex), 32'(k));
  endtask
  task automatic march();
    bus.frameTick = 1'b1;
    cyc(1);
    bus.frameTick = 1'b0;
    cyc(34);
  endtask
  initial begin
    bus.frameTick = 1'b0;
    bus.hPos = '0;
    bus.vPos = '0;
    bus.hitValid = 1'b0;
    bus.hitX = '0;
    bus.hitY = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_x", 32'(bus.xAlien), 100);
    chk("rst_y", 32'(bus.yAlien), 40);
    chk("rst_alive", 32'(bus.alive), 32'hFFFF_FFFF);
    chk("rst_count", 32'(bus.aliveCount), 32);
    chk("rst_color", 32'(bus.colorAlien), 0);
    chk("rst_kill", 32'(bus.hitKill), 0);
    chk("rst_idx", 32'(bus.hitIndex), 0);
    chk("rst_dead", 32'(bus.allDead), 0);
    chk("rst_inv", 32'(bus.invaded), 0);
    pix("pix_100_40", 100, 40, 2);
    pix("pix_140_40", 140, 40, 3);
    pix("pix_99_40", 99, 40, 0);
    pix("pix_100_50", 100, 50, 0);
    pix("pix_119_49", 119, 49, 2);
    pix("pix_120_40", 120, 40, 0);
    pix("pix_180_60", 180, 60, 4);
    pix("pix_220_40", 220, 40, 5);
    pix("pix_100_60", 100, 60, 2);
    kill("hit1", 145, 45, 1);
    chk("hit1_alive1", 32'(bus.alive[1]), 0);
    chk("hit1_count", 32'(bus.aliveCount), 31);
    cyc(1);
    chk("hit1_pulse_end", 32'(bus.hitKill), 0);
    shoot(145, 45);
    chk("rehit_kill", 32'(bus.hitKill), 0);
    chk("rehit_count", 32'(bus.aliveCount), 31);
    shoot(125, 45);
    chk("gap_kill", 32'(bus.hitKill), 0);
    pix("pix_dead_cell", 140, 40, 0);
    bus.frameTick = 1'b1;
    cyc(1);
    bus.frameTick = 1'b0;
    cyc(4);
    bus.frameTick = 1'b1;
    cyc(1);
    bus.frameTick = 1'b0;
    cyc(27);
    chk("march_early", 32'(bus.xAlien), 100);
    cyc(1);
    chk("march_x", 32'(bus.xAlien), 104);
    chk("march_y", 32'(bus.yAlien), 40);
    cyc(40);
    chk("scan_tick_ignored", 32'(bus.xAlien), 104);
    for (int r = 0; r < 4; r++) kill("col7", 390, 45 + 20 * r, r * 8 + 7);
    chk("col7_count", 32'(bus.aliveCount), 27);
    for (int i = 0; i < 66; i++) march();
    chk("edge_x", 32'(bus.xAlien), 368);
    chk("edge_y", 32'(bus.yAlien), 40);
    march();
    chk("desc_x", 32'(bus.xAlien), 368);
    chk("desc_y", 32'(bus.yAlien), 50);
    march();
    chk("left_x", 32'(bus.xAlien), 364);
    chk("left_y", 32'(bus.yAlien), 50);
    for (int k = 0; k < 27; k++)
      if (k != 1 && k != 7 && k != 15 && k != 23) kill("sweep", 366 + 40 * (k % 8), 52 + 20 * (k / 8), k);
    chk("four_left", 32'(bus.aliveCount), 4);
    march();
    chk("four_step_x", 32'(bus.xAlien), 360);
    for (int k = 27; k < 31; k++) kill("last", 362 + 40 * (k % 8), 112, k);
    chk("dead_flag", 32'(bus.allDead), 1);
    chk("dead_count", 32'(bus.aliveCount), 0);
    chk("dead_mask", 32'(bus.alive), 0);
    march();
    march();
    chk("dead_hold_x", 32'(bus.xAlien), 360);
    chk("dead_hold_y", 32'(bus.yAlien), 50);
    chk("no_invade", 32'(bus.invaded), 0);
    bus.hPos = '0;
    bus.vPos = '0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rst2_x", 32'(bus.xAlien), 100);
    chk("rst2_y", 32'(bus.yAlien), 40);
    chk("rst2_count", 32'(bus.aliveCount), 32);
    chk("rst2_dead", 32'(bus.allDead), 0);
    kill("rst2_hit", 102, 42, 0);
    chk("rst2_hit_count", 32'(bus.aliveCount), 31);
    bus.frameTick = 1'b1;
    cyc(1);
    bus.frameTick = 1'b0;
    cyc(10);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midscan_kill", 32'(bus.hitKill), 0);
    chk("midscan_idx", 32'(bus.hitIndex), 0);
    chk("midscan_count", 32'(bus.aliveCount), 32);
    chk("midscan_alive", 32'(bus.alive), 32'hFFFF_FFFF);
    cyc(40);
    chk("midscan_x", 32'(bus.xAlien), 100);
    chk("midscan_y", 32'(bus.yAlien), 40);
    chk("midscan_color", 32'(bus.colorAlien), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
